apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
// PURPOSE
//  - APB3 requester: turns a valid/ready command stream (addr, wdata, write) into single APB transfers.
//  - Drives the Hub75 control/status and frame-buffer register slave from a streaming source (DMA, UART bridge, BIST).
//  - Returns one response per command (read data plus error flag) on a valid/ready response stream.
// PARAMETERS
//  ADDR_W          18    APB byte-address width; bits [1:0] must be 00.
//  DATA_W          32    APB data width.
//  TIMEOUT_CYCLES  255   max access-phase cycles waiting for pready; used only with APB_MASTER_TIMEOUT_EN.
// PORTS
//  pclk        in   1       single clock for all logic.
//  preset      in   1       synchronous, active-high reset.
//  cmd_valid   in   1       command present.
//  cmd_ready   out  1       command accepted when cmd_valid & cmd_ready.
//  cmd_write   in   1       1 = write, 0 = read.
//  cmd_addr    in   ADDR_W  byte address.
//  cmd_wdata   in   DATA_W  write data; ignored on reads.
//  rsp_valid   out  1       response present.
//  rsp_ready   in   1       response consumed when rsp_valid & rsp_ready.
//  rsp_rdata   out  DATA_W  read data; 0 for writes and errors.
//  rsp_err     out  1       pslverr, misaligned address, or timeout.
//  psel        out  1       APB select.
//  penable     out  1       APB access phase.
//  pwrite      out  1       APB direction.
//  paddr       out  ADDR_W  APB address.
//  pwdata      out  DATA_W  APB write data.
//  prdata      in   DATA_W  APB read data.
//  pready      in   1       APB ready; tie to 1 for slaves without wait states.
//  pslverr     in   1       APB error; tie to 0 if unused.
// BEHAVIOUR
//  - Reset (synchronous, preset=1 at a pclk edge):
//    - state=IDLE.
//    - psel, penable, pwrite, rsp_valid, rsp_err = 0.
//    - paddr, pwdata, rsp_rdata = 0.
//    - cmd_ready=0 during reset and 1 from the first cycle after it.
//  - Reset mid-transfer: psel and penable drop at that same edge. The pending response is discarded.
//  - FSM has four states: IDLE, SETUP, ACCESS, RESP.
//    - IDLE: cmd_ready=1. On handshake, register cmd_* into paddr/pwrite/pwdata.
//      - Aligned address (cmd_addr[1:0]==00): go to SETUP.
//      - Misaligned address: go to RESP with rsp_err=1 and rsp_rdata=0. No APB transfer is issued.
//    - SETUP: psel=1, penable=0. Always goes to ACCESS next cycle.
//    - ACCESS: psel=1, penable=1. paddr, pwrite and pwdata are held stable.
//      - While pready=0, stay in ACCESS.
//      - When pready=1:
//        - capture rsp_err=pslverr.
//        - capture rsp_rdata = (!pwrite && !pslverr) ? prdata : 0.
//        - deassert psel and penable.
//        - go to RESP.
//    - RESP: rsp_valid=1 and response fields held stable until rsp_ready=1, then go to IDLE.
//  - cmd_ready is high only in IDLE, so there is one outstanding command and no back-to-back APB transfers.
//  - Latency with zero wait states: handshake at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
//    - Each pready=0 cycle adds one cycle.
//    - A command can be re-accepted at the earliest one cycle after the response handshake.
//  - psel is never high outside SETUP/ACCESS. penable is only ever high in the cycle after SETUP.
//  - The response is held even if the slave changes prdata after the transfer.
// CONFIGURATION
//  - APB_MASTER_TIMEOUT_EN defined:
//    - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entering ACCESS and increments on each pready=0 cycle.
//    - When the count reaches TIMEOUT_CYCLES with pready still 0, the transfer is abandoned:
//      psel/penable drop, go to RESP, rsp_err=1, rsp_rdata=0.
//    - If pready=1 in the same cycle the limit is reached, the transfer completes normally.
//  - APB_MASTER_TIMEOUT_EN undefined: no counter; ACCESS waits for pready indefinitely.
// STRUCTURE
//  - hub75_apb_pkg holds:
//    - the FSM state encoding (IDLE/SETUP/ACCESS/RESP).
//    - ADDR_W/DATA_W defaults.
//    - slave byte addresses: STATUS 0x20000, CONTROL_0 0x20004, PPROW_0 0x20008, BCM_7..BCM_2 0x2000C..0x20020.
//    - STATUS_MAGIC 0xDEADBEEF.
//  - Single flat module; no sub-module (the timeout counter is inline under the macro).
// TESTING
//  - Connect to the Hub75 register slave (pready=1, pslverr=0).
//  1. Read 0x20000 -> psel cycle 1, penable cycle 2, rsp_valid cycle 3, rsp_rdata=0xDEADBEEF, rsp_err=0.
//  2. Write 0x20008 = 0x80, then read 0x20008 -> rsp_rdata=0x00000080. Write response has rsp_rdata=0, rsp_err=0.
//  3. Read with pready low 3 cycles -> ACCESS lasts 4 cycles, paddr stable, rsp_valid 3 cycles later than test 1.
//     - Hold rsp_ready=0 for 5 cycles -> response stable and cmd_ready=0 throughout.
//  4. cmd_addr=0x20002 -> no psel pulse; rsp_valid 1 cycle after handshake; rsp_err=1.
//     - pslverr=1 on a read -> rsp_err=1, rsp_rdata=0.
//  5. preset=1 during ACCESS -> psel=0, penable=0, rsp_valid=0 next cycle; a following read of 0x20000 returns 0xDEADBEEF.
//  6. With APB_MASTER_TIMEOUT_EN and pready stuck at 0 -> abort after 255 ACCESS cycles, rsp_err=1.
//     - Without the macro -> still in ACCESS after 1000 cycles.

Source files
------------

// File: rtl/hub75_apb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hub75_apb_pkg
//  Description : Shared definitions for the APB command requester that drives
//                the Hub75 control/status and frame-buffer register slave:
//                FSM state encoding, default bus widths, slave register byte
//                addresses and the STATUS magic value.
//  Revision    : 1.0 - initial release
// ============================================================================
package hub75_apb_pkg;

    // Default bus widths
    localparam int c_ADDR_W_DEFAULT = 18;
    localparam int c_DATA_W_DEFAULT = 32;

    // Requester FSM state encoding
    typedef logic [1:0] apb_state_t;
    localparam apb_state_t c_ST_IDLE   = 2'd0;
    localparam apb_state_t c_ST_SETUP  = 2'd1;
    localparam apb_state_t c_ST_ACCESS = 2'd2;
    localparam apb_state_t c_ST_RESP   = 2'd3;

    // Hub75 register slave byte addresses
    localparam logic [17:0] c_ADDR_STATUS    = 18'h20000;
    localparam logic [17:0] c_ADDR_CONTROL_0 = 18'h20004;
    localparam logic [17:0] c_ADDR_PPROW_0   = 18'h20008;
    localparam logic [17:0] c_ADDR_BCM_7     = 18'h2000C;
    localparam logic [17:0] c_ADDR_BCM_6     = 18'h20010;
    localparam logic [17:0] c_ADDR_BCM_5     = 18'h20014;
    localparam logic [17:0] c_ADDR_BCM_4     = 18'h20018;
    localparam logic [17:0] c_ADDR_BCM_3     = 18'h2001C;
    localparam logic [17:0] c_ADDR_BCM_2     = 18'h20020;

    // Fixed value returned by the STATUS register
    localparam logic [31:0] c_STATUS_MAGIC = 32'hDEADBEEF;

endpackage : hub75_apb_pkg
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : apb_cmd_master
//  Description : APB3 requester. Accepts one command at a time from a
//                valid/ready stream (addr, wdata, write), performs a single
//                APB transfer and returns one response (rdata, err) on a
//                valid/ready response stream. Misaligned addresses are
//                rejected with an error response and no bus transfer.
//  Option      : APB_MASTER_TIMEOUT_EN - when defined, an access phase that
//                waits TIMEOUT_CYCLES cycles without pready is abandoned and
//                answered with an error response.
//  Ports       : pclk/preset            - clock, synchronous active-high reset
//                cmd_*                  - command stream in
//                rsp_*                  - response stream out
//                psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr
//                                       - APB3 requester interface
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_cmd_master
    import hub75_apb_pkg::*;
#(
    parameter int ADDR_W         = c_ADDR_W_DEFAULT,
    parameter int DATA_W         = c_DATA_W_DEFAULT
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              pclk,
    input  logic              preset,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB3 requester
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t        r_state_q;
    apb_state_t        w_state_d;

    logic [ADDR_W-1:0] r_paddr_q;
    logic              r_pwrite_q;
    logic [DATA_W-1:0] r_pwdata_q;
    logic [DATA_W-1:0] r_rdata_q;
    logic              r_err_q;

    logic              w_cmd_hs;
    logic              w_misaligned;
    logic              w_timeout;

    assign w_cmd_hs     = cmd_valid & cmd_ready;
    assign w_misaligned = (cmd_addr[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Access-phase timeout
    // ------------------------------------------------------------------
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Abort in the wait cycle whose increment would make the count reach
    // TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES access cycles without pready.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_wait_cnt_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wait_cnt_q <= '0;
        end else if (r_state_q == c_ST_SETUP) begin
            r_wait_cnt_q <= '0;
        end else if ((r_state_q == c_ST_ACCESS) && !pready) begin
            r_wait_cnt_q <= r_wait_cnt_q + 1'b1;
        end
    end

    // pready wins over the limit: a transfer completing in the limit cycle
    // finishes normally.
    assign w_timeout = !pready && (r_wait_cnt_q == c_CNT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_cmd_hs) begin
                    // Misaligned commands skip the bus and answer directly.
                    w_state_d = w_misaligned ? c_ST_RESP : c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                w_state_d = c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                if (pready || w_timeout) begin
                    w_state_d = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (r_state_q)
            // Held low while reset is asserted, even if already in IDLE.
            c_ST_IDLE:   cmd_ready = !preset;
            c_ST_SETUP:  psel      = 1'b1;
            c_ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            c_ST_RESP:   rsp_valid = 1'b1;
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_paddr_q  <= '0;
            r_pwrite_q <= 1'b0;
            r_pwdata_q <= '0;
            r_rdata_q  <= '0;
            r_err_q    <= 1'b0;
        end else begin
            case (r_state_q)
                c_ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_paddr_q  <= cmd_addr;
                        r_pwrite_q <= cmd_write;
                        r_pwdata_q <= cmd_wdata;
                        r_rdata_q  <= '0;
                        r_err_q    <= w_misaligned;
                    end
                end
                c_ST_ACCESS: begin
                    if (pready) begin
                        r_err_q   <= pslverr;
                        r_rdata_q <= (!r_pwrite_q && !pslverr) ? prdata : '0;
                    end else if (w_timeout) begin
                        r_err_q   <= 1'b1;
                        r_rdata_q <= '0;
                    end
                end
                default: begin
                    r_err_q <= r_err_q;
                end
            endcase
        end
    end

    assign paddr     = r_paddr_q;
    assign pwrite    = r_pwrite_q;
    assign pwdata    = r_pwdata_q;
    assign rsp_rdata = r_rdata_q;
    assign rsp_err   = r_err_q;

endmodule : apb_cmd_master
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_apb_cmd_master
//  Description : Self-checking bench for apb_cmd_master against a behavioural
//                Hub75 register slave (STATUS magic + eight RW registers).
//                Expected responses are queued when commands are issued and
//                popped by a monitor on every response handshake.
//  Option      : APB_MASTER_TIMEOUT_EN selects the timeout expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;
    import hub75_apb_pkg::*;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [17:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [17:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t exp_q[$];

    always #5 pclk = ~pclk;

    apb_cmd_master dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    // ------------------------------------------------------------------
    // Hub75 register slave model: index 0 is STATUS, 1..8 are RW registers.
    // prdata shows garbage while unselected so held responses are exercised.
    // ------------------------------------------------------------------
    logic [31:0] regs [0:8];
    logic [17:0] slv_off;
    logic [15:0] slv_idx;

    assign slv_off = paddr - c_ADDR_STATUS;
    assign slv_idx = slv_off[17:2];

    initial begin
        for (int i = 0; i < 9; i++) regs[i] = 32'h0;
    end

    always @(posedge pclk) begin
        if (psel && penable && pready && pwrite && !pslverr &&
            slv_idx >= 16'd1 && slv_idx <= 16'd8) begin
            regs[slv_idx[3:0]] <= pwdata;
        end
    end

    always_comb begin
        prdata = 32'hBAD0BAD0;
        if (psel) begin
            if (slv_idx == 16'd0)      prdata = c_STATUS_MAGIC;
            else if (slv_idx <= 16'd8) prdata = regs[slv_idx[3:0]];
            else                       prdata = 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge pclk) begin
        if (!preset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata=0x%0h err=%0d expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
                chk("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
            end
        end
    end

    // Issue one command; returns 1 ns after the accepting edge (cycle 1).
    task automatic send(input logic w, input logic [17:0] a, input logic [31:0] d,
                        input bit push, input logic [31:0] er, input logic ee);
        int n;
        rsp_t e;
        @(posedge pclk);
        #1;
        if (push) begin
            e.err   = ee;
            e.rdata = er;
            exp_q.push_back(e);
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        @(negedge pclk);
        while (!cmd_ready && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) chk("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        chk("rsp_drain", {32'h0, exp_q.size()}, 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        pready    = 1'b1;
        pslverr   = 1'b0;

        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'd0);
        chk("rst_psel",      {63'h0, psel},      64'd0);
        chk("rst_penable",   {63'h0, penable},   64'd0);
        chk("rst_pwrite",    {63'h0, pwrite},    64'd0);
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'd0);
        chk("rst_rsp_err",   {63'h0, rsp_err},   64'd0);
        chk("rst_paddr",     {46'h0, paddr},     64'd0);
        chk("rst_pwdata",    {32'h0, pwdata},    64'd0);
        chk("rst_rsp_rdata", {32'h0, rsp_rdata}, 64'd0);
        @(posedge pclk);
        #1;
        preset = 1'b0;
        @(negedge pclk);
        chk("post_rst_cmd_ready", {63'h0, cmd_ready}, 64'd1);

        // 1. STATUS read with exact cycle timing
        send(1'b0, c_ADDR_STATUS, 32'h0, 1'b1, c_STATUS_MAGIC, 1'b0);
        @(negedge pclk);
        chk("t1_c1_psel_penable", {62'h0, psel, penable}, 64'd2);
        @(negedge pclk);
        chk("t1_c2_psel_penable", {62'h0, psel, penable}, 64'd3);
        @(negedge pclk);
        chk("t1_c3_rsp_valid", {63'h0, rsp_valid}, 64'd1);
        wait_drain();

        // 2. Register writes and read-backs
        send(1'b1, c_ADDR_PPROW_0, 32'h00000080, 1'b1, 32'h0, 1'b0);
        send(1'b0, c_ADDR_PPROW_0, 32'h0,        1'b1, 32'h00000080, 1'b0);
        send(1'b1, c_ADDR_BCM_7,   32'h12345678, 1'b1, 32'h0, 1'b0);
        send(1'b1, c_ADDR_BCM_2,   32'hA5A50001, 1'b1, 32'h0, 1'b0);
        send(1'b0, c_ADDR_BCM_7,   32'h0,        1'b1, 32'h12345678, 1'b0);
        send(1'b0, c_ADDR_BCM_2,   32'h0,        1'b1, 32'hA5A50001, 1'b0);
        send(1'b0, c_ADDR_CONTROL_0, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
        wait_drain();

        // 3. Three wait states, then response back-pressure for 5 cycles
        pready    = 1'b0;
        rsp_ready = 1'b0;
        send(1'b0, c_ADDR_STATUS, 32'h0, 1'b1, c_STATUS_MAGIC, 1'b0);
        @(negedge pclk);
        chk("t3_c1_psel_penable", {62'h0, psel, penable}, 64'd2);
        for (int c = 2; c <= 4; c++) begin
            @(negedge pclk);
            chk("t3_wait_penable", {63'h0, penable}, 64'd1);
            chk("t3_wait_paddr", {46'h0, paddr}, {46'h0, c_ADDR_STATUS});
        end
        @(posedge pclk);
        #1;
        pready = 1'b1;
        @(negedge pclk);
        chk("t3_c5_penable", {63'h0, penable}, 64'd1);
        chk("t3_c5_paddr", {46'h0, paddr}, {46'h0, c_ADDR_STATUS});
        for (int c = 6; c <= 10; c++) begin
            @(negedge pclk);
            chk("t3_hold_rsp_valid", {63'h0, rsp_valid}, 64'd1);
            chk("t3_hold_rsp_rdata", {32'h0, rsp_rdata}, {32'h0, c_STATUS_MAGIC});
            chk("t3_hold_cmd_ready", {63'h0, cmd_ready}, 64'd0);
            chk("t3_hold_psel", {63'h0, psel}, 64'd0);
        end
        @(posedge pclk);
        #1;
        rsp_ready = 1'b1;
        wait_drain();

        // 4. Misaligned address and slave error
        send(1'b0, 18'h20002, 32'h0, 1'b1, 32'h0, 1'b1);
        @(negedge pclk);
        chk("t4_misaligned_psel", {63'h0, psel}, 64'd0);
        chk("t4_misaligned_rsp_valid", {63'h0, rsp_valid}, 64'd1);
        wait_drain();
        pslverr = 1'b1;
        send(1'b0, c_ADDR_STATUS, 32'h0, 1'b1, 32'h0, 1'b1);
        wait_drain();
        pslverr = 1'b0;

        // 5. Reset while in ACCESS discards the transfer
        pready = 1'b0;
        send(1'b0, c_ADDR_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge pclk);
        @(negedge pclk);
        chk("t5_in_access", {63'h0, penable}, 64'd1);
        @(posedge pclk);
        #1;
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
        @(negedge pclk);
        chk("t5_after_rst_bus", {61'h0, psel, penable, rsp_valid}, 64'd0);
        pready = 1'b1;
        send(1'b0, c_ADDR_STATUS, 32'h0, 1'b1, c_STATUS_MAGIC, 1'b0);
        wait_drain();

        // 6. Slave never ready
        pready = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        send(1'b0, c_ADDR_STATUS, 32'h0, 1'b1, 32'h0, 1'b1);
        @(negedge pclk);
        @(negedge pclk);
        n = 0;
        while (penable && n < 2000) begin
            n++;
            @(negedge pclk);
        end
        chk("t6_access_cycles", {32'h0, n}, 64'd255);
        chk("t6_abort_rsp_valid", {63'h0, rsp_valid}, 64'd1);
        wait_drain();
`else
        send(1'b0, c_ADDR_STATUS, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (1001) @(negedge pclk);
        chk("t6_still_access", {62'h0, psel, penable}, 64'd3);
        @(posedge pclk);
        #1;
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
`endif
        pready = 1'b1;
        send(1'b1, c_ADDR_BCM_4, 32'h0000CAFE, 1'b1, 32'h0, 1'b0);
        send(1'b0, c_ADDR_BCM_4, 32'h0,        1'b1, 32'h0000CAFE, 1'b0);
        wait_drain();

        repeat (3) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_apb_cmd_master
`default_nettype wire
